// File: rtl/cache_ctrl_pkg.sv
// rtl/cache_ctrl_pkg.sv - shared types and constants for the cache controller
package cache_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        COMPARE   = 2'd1,
        WRITEBACK = 2'd2,
        FILL      = 2'd3
    } state_t;

    localparam int MEM_LATENCY_DEF = 20;
    localparam int CNT_W           = 8;

endpackage

// File: rtl/latency_counter.sv
// rtl/latency_counter.sv - down-counter timing one main-memory access
module latency_counter
    import cache_ctrl_pkg::*;
#(
    parameter int LOAD_VAL = MEM_LATENCY_DEF - 1
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic last
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (start) begin
            count <= CNT_W'(LOAD_VAL);
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign last = (count == '0);

endmodule

// File: rtl/cache_controller.sv
// rtl/cache_controller.sv - blocking cache miss controller with write-back and fill
module cache_controller
    import cache_ctrl_pkg::*;
#(
    parameter int MEM_LATENCY = MEM_LATENCY_DEF,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              re,
    input  logic              we,
    input  logic [ADDR_W-1:0] address,
    input  logic              hit,
    input  logic              dirty,
    input  logic [ADDR_W-1:0] victim_addr,
    output logic              stall,
    output logic              done,
    output logic              cache_we,
    output logic              fill_we,
    output logic              mem_re,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       hit_count,
    output logic [15:0]       miss_count
);

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic              op_we;
    logic              first;
    logic              last;
    logic              cnt_start;

    // The counter is reloaded on every entry into WRITEBACK or FILL
    assign cnt_start = (state == COMPARE && !hit) || (state == WRITEBACK && last);

    latency_counter #(
        .LOAD_VAL(MEM_LATENCY - 1)
    ) u_lat (
        .clk  (clk),
        .reset(reset),
        .start(cnt_start),
        .last (last)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            addr_q     <= '0;
            op_we      <= 1'b0;
            first      <= 1'b0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (re || we) begin
                        addr_q <= address;
                        op_we  <= we;
                        first  <= 1'b1;
                        state  <= COMPARE;
                    end
                end
                COMPARE: begin
                    first <= 1'b0;
                    // Only the first compare of a request is counted; retries are not
                    if (first) begin
                        if (hit) begin
                            if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
                        end else begin
                            if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
                        end
                    end
                    if (hit)        state <= IDLE;
                    else if (dirty) state <= WRITEBACK;
                    else            state <= FILL;
                end
                WRITEBACK: if (last) state <= FILL;
                FILL:      if (last) state <= COMPARE;
                default:   state <= IDLE;
            endcase
        end
    end

    always_comb begin
        stall    = (state != IDLE);
        done     = (state == COMPARE) && hit;
        cache_we = (state == COMPARE) && hit && op_we;
        fill_we  = (state == FILL) && last;
        mem_re   = (state == FILL);
        mem_we   = (state == WRITEBACK);
        mem_addr = '0;
        if (state == WRITEBACK) mem_addr = victim_addr;
        else if (state == FILL) mem_addr = {addr_q[ADDR_W-1:2], 2'b00};
    end

endmodule

// File: tb/tb_cache_controller.sv
// tb/tb_cache_controller.sv - directed self-checking bench for cache_controller
module tb_cache_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        re = 1'b0;
    logic        we = 1'b0;
    logic [31:0] address = '0;
    logic        hit = 1'b0;
    logic        dirty = 1'b0;
    logic [31:0] victim_addr = '0;
    logic        stall, done, cache_we, fill_we, mem_re, mem_we;
    logic [31:0] mem_addr;
    logic [15:0] hit_count, miss_count;

    int n_cmp = 0;
    int n_err = 0;

    cache_controller #(.MEM_LATENCY(20), .ADDR_W(32)) dut (
        .clk(clk), .reset(reset), .re(re), .we(we), .address(address),
        .hit(hit), .dirty(dirty), .victim_addr(victim_addr),
        .stall(stall), .done(done), .cache_we(cache_we), .fill_we(fill_we),
        .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_stall"}, 32'(stall), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_cache_we"}, 32'(cache_we), 32'd0);
        chk({tag, "_fill_we"}, 32'(fill_we), 32'd0);
        chk({tag, "_mem_re"}, 32'(mem_re), 32'd0);
        chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_mem_addr"}, mem_addr, 32'd0);
        chk({tag, "_hit_count"}, 32'(hit_count), 32'd0);
        chk({tag, "_miss_count"}, 32'(miss_count), 32'd0);
    endtask

    // Drive a request before an edge; returns sampled in cycle 1
    task automatic issue(input logic r, input logic w, input logic [31:0] a);
        re = r; we = w; address = a;
        @(negedge clk);
        re = 1'b0; we = 1'b0;
    endtask

    // Checks cycles c0..c1 of a memory phase; fill_we only on the last FILL cycle
    task automatic phase(input string tag, input int c0, input int c1,
                         input logic mre, input logic mwe, input logic [31:0] maddr);
        for (int c = c0; c <= c1; c++) begin
            chk({tag, "_mem_re"}, 32'(mem_re), 32'(mre));
            chk({tag, "_mem_we"}, 32'(mem_we), 32'(mwe));
            chk({tag, "_mem_addr"}, mem_addr, maddr);
            chk({tag, "_fill_we"}, 32'(fill_we), 32'(mre && (c == c1)));
            chk({tag, "_done"}, 32'(done), 32'd0);
            chk({tag, "_stall"}, 32'(stall), 32'd1);
            @(negedge clk);
        end
    endtask

    initial begin
        #2;
        chk_all_zero("reset");
        @(negedge clk);
        reset = 1'b1;

        // Read hit, accepted at the first edge after reset
        hit = 1'b1;
        issue(1'b1, 1'b0, 32'h0000_4012);
        chk("rh_stall", 32'(stall), 32'd1);
        chk("rh_done", 32'(done), 32'd1);
        chk("rh_cache_we", 32'(cache_we), 32'd0);
        @(negedge clk);
        chk("rh_stall2", 32'(stall), 32'd0);
        chk("rh_done2", 32'(done), 32'd0);
        chk("rh_hit_count", 32'(hit_count), 32'd1);

        // Clean write miss
        hit = 1'b0; dirty = 1'b0;
        issue(1'b0, 1'b1, 32'h0000_4012);
        chk("cw_done1", 32'(done), 32'd0);
        chk("cw_stall1", 32'(stall), 32'd1);
        @(negedge clk);
        chk("cw_miss_count", 32'(miss_count), 32'd1);
        hit = 1'b1;
        phase("cw_fill", 2, 21, 1'b1, 1'b0, 32'h0000_4010);
        chk("cw_done22", 32'(done), 32'd1);
        chk("cw_cache_we22", 32'(cache_we), 32'd1);
        chk("cw_mem_addr22", mem_addr, 32'd0);
        @(negedge clk);
        chk("cw_stall23", 32'(stall), 32'd0);
        chk("cw_miss_final", 32'(miss_count), 32'd1);
        chk("cw_hit_final", 32'(hit_count), 32'd1);

        // Dirty read miss
        hit = 1'b0; dirty = 1'b1; victim_addr = 32'h0000_4010;
        issue(1'b1, 1'b0, 32'h0000_8012);
        @(negedge clk);
        dirty = 1'b0;
        phase("dr_wb", 2, 21, 1'b0, 1'b1, 32'h0000_4010);
        hit = 1'b1;
        phase("dr_fill", 22, 41, 1'b1, 1'b0, 32'h0000_8010);
        chk("dr_done42", 32'(done), 32'd1);
        chk("dr_cache_we42", 32'(cache_we), 32'd0);
        @(negedge clk);
        chk("dr_miss_count", 32'(miss_count), 32'd2);

        // Miss on retry repeats the fill without a second miss count
        hit = 1'b0; dirty = 1'b0;
        issue(1'b0, 1'b1, 32'h0000_0103);
        @(negedge clk);
        phase("rt_fill1", 2, 21, 1'b1, 1'b0, 32'h0000_0100);
        chk("rt_done22", 32'(done), 32'd0);
        @(negedge clk);
        hit = 1'b1;
        phase("rt_fill2", 23, 42, 1'b1, 1'b0, 32'h0000_0100);
        chk("rt_done43", 32'(done), 32'd1);
        chk("rt_cache_we43", 32'(cache_we), 32'd1);
        @(negedge clk);
        chk("rt_miss_count", 32'(miss_count), 32'd3);
        chk("rt_hit_count", 32'(hit_count), 32'd1);

        // Simultaneous read and write is a write
        hit = 1'b1;
        issue(1'b1, 1'b1, 32'h0000_8011);
        chk("rw_done", 32'(done), 32'd1);
        chk("rw_cache_we", 32'(cache_we), 32'd1);
        @(negedge clk);
        chk("rw_hit_count", 32'(hit_count), 32'd2);

        // Reset in FILL cycle 10 aborts at once
        hit = 1'b0; dirty = 1'b0;
        issue(1'b0, 1'b1, 32'h0000_0200);
        repeat (10) @(negedge clk);
        chk("ab_mem_re_pre", 32'(mem_re), 32'd1);
        reset = 1'b0;
        #1;
        chk_all_zero("ab");
        @(negedge clk);
        chk("ab_fill_we_held", 32'(fill_we), 32'd0);
        reset = 1'b1;
        hit = 1'b1;
        issue(1'b1, 1'b0, 32'h0000_0300);
        chk("ab_new_done", 32'(done), 32'd1);
        @(negedge clk);
        chk("ab_new_hit_count", 32'(hit_count), 32'd1);
        chk("ab_new_miss_count", 32'(miss_count), 32'd0);

        // Hit counter saturation
        force dut.hit_count = 16'hFFFF;
        @(negedge clk);
        release dut.hit_count;
        @(negedge clk);
        chk("sat_preload", 32'(hit_count), 32'h0000_FFFF);
        issue(1'b1, 1'b0, 32'h0000_0400);
        chk("sat_done", 32'(done), 32'd1);
        @(negedge clk);
        chk("sat_hit_count", 32'(hit_count), 32'h0000_FFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
